// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, ACKs every write byte, serialises tx_data on reads, no clock stretching.
// Bus events act 3 clk after the pins, outputs follow 1 clk later; tx_data must be valid by the end of each ACK slot.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       rd_mode
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
    } state_t;

    state_t     state, state_nx;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic [2:0] cnt, cnt_nx;
    logic [6:0] shreg, shreg_nx;
    logic       sda_oe, sda_oe_nx;
    logic       rd_load, rd_load_nx;
    logic [7:0] rx_data_nx;
    logic       rx_valid_nx, tx_req_nx, busy_nx, rd_mode_nx;
    logic       scl_rise, scl_fall, start_evt, stop_evt;
    logic [7:0] byte_in;

    assign sda       = sda_oe ? 1'b0 : 1'bz;
    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_evt = scl_s2 & scl_d & ~sda_s2 & sda_d;
    assign stop_evt  = scl_s2 & scl_d & sda_s2 & ~sda_d;
    // Only seven bits are held; the eighth arrives on the current rise.
    assign byte_in   = {shreg, sda_s2};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_d    <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_d    <= 1'b1;
            state    <= IDLE;
            cnt      <= 3'd0;
            shreg    <= 7'd0;
            sda_oe   <= 1'b0;
            rd_load  <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
            rd_mode  <= 1'b0;
        end else begin
            scl_s1   <= scl;
            scl_s2   <= scl_s1;
            scl_d    <= scl_s2;
            sda_s1   <= sda;
            sda_s2   <= sda_s1;
            sda_d    <= sda_s2;
            state    <= state_nx;
            cnt      <= cnt_nx;
            shreg    <= shreg_nx;
            sda_oe   <= sda_oe_nx;
            rd_load  <= rd_load_nx;
            rx_data  <= rx_data_nx;
            rx_valid <= rx_valid_nx;
            tx_req   <= tx_req_nx;
            busy     <= busy_nx;
            rd_mode  <= rd_mode_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        shreg_nx    = shreg;
        sda_oe_nx   = sda_oe;
        rd_load_nx  = rd_load;
        rx_data_nx  = rx_data;
        rx_valid_nx = 1'b0;
        tx_req_nx   = 1'b0;
        busy_nx     = busy;
        rd_mode_nx  = rd_mode;
        if (start_evt) begin
            state_nx   = ADDR;
            cnt_nx     = 3'd0;
            shreg_nx   = 7'd0;
            sda_oe_nx  = 1'b0;
            rd_load_nx = 1'b0;
            busy_nx    = 1'b0;
        end else if (stop_evt) begin
            state_nx   = IDLE;
            sda_oe_nx  = 1'b0;
            rd_load_nx = 1'b0;
            busy_nx    = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shreg_nx = byte_in[6:0];
                    cnt_nx   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (byte_in[7:1] == SLAVE_ADDR) begin
                            rd_mode_nx = byte_in[0];
                            busy_nx    = 1'b1;
                            state_nx   = ADDR_ACK;
                        end else begin
                            state_nx = IGNORE;
                        end
                    end
                end
                // sda_oe doubles as the "ACK already driven" phase flag.
                ADDR_ACK: if (scl_fall) begin
                    cnt_nx = 3'd0;
                    if (!sda_oe) begin
                        sda_oe_nx = 1'b1;
                        tx_req_nx = rd_mode;
                    end else if (rd_mode) begin
                        state_nx   = RD;
                        shreg_nx   = tx_data[6:0];
                        sda_oe_nx  = ~tx_data[7];
                        rd_load_nx = 1'b0;
                    end else begin
                        state_nx  = WR;
                        sda_oe_nx = 1'b0;
                    end
                end
                WR: if (scl_rise) begin
                    shreg_nx = byte_in[6:0];
                    cnt_nx   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        rx_data_nx  = byte_in;
                        rx_valid_nx = 1'b1;
                        state_nx    = WR_ACK;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    sda_oe_nx = ~sda_oe;
                    if (sda_oe) state_nx = WR;
                end
                RD: if (scl_fall) begin
                    if (rd_load) begin
                        rd_load_nx = 1'b0;
                        cnt_nx     = 3'd0;
                        shreg_nx   = tx_data[6:0];
                        sda_oe_nx  = ~tx_data[7];
                    end else if (cnt == 3'd7) begin
                        sda_oe_nx = 1'b0;
                        cnt_nx    = 3'd0;
                        state_nx  = RD_ACK;
                    end else begin
                        sda_oe_nx = ~shreg[6];
                        shreg_nx  = {shreg[5:0], 1'b0};
                        cnt_nx    = cnt + 3'd1;
                    end
                end
                RD_ACK: if (scl_rise) begin
                    if (!sda_s2) begin
                        tx_req_nx  = 1'b1;
                        rd_load_nx = 1'b1;
                        state_nx   = RD;
                    end else begin
                        state_nx = IGNORE;
                    end
                end
                IDLE, IGNORE: sda_oe_nx = 1'b0;
                default: begin
                    state_nx  = IDLE;
                    sda_oe_nx = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bus master model issues transfers and queues expectations; a monitor drains them.
module tb_i2c_slave;
    localparam int H = 8;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl     = 1'b1;
    logic       m_low   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, busy, rd_mode;

    int         n_tests    = 0;
    int         n_fail     = 0;
    int         tx_req_cnt = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] tx_q[$];
    string      cname_q[$];
    logic [31:0] cact_q[$];
    logic [31:0] cexp_q[$];

    always #5 clk = ~clk;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl      (scl),
        .sda      (sda),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .rd_mode  (rd_mode)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic void expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        cname_q.push_back(name);
        cact_q.push_back(act);
        cexp_q.push_back(exp);
    endfunction

    // Monitor: scores every rx_valid pulse against the queue and drains queued comparisons.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (exp_rx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_unexpected: got rx_valid with rx_data 0x%02h, required no rx_valid", rx_data);
            end else begin
                cmp("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
            end
        end
        while (cname_q.size() != 0)
            cmp(cname_q.pop_front(), cact_q.pop_front(), cexp_q.pop_front());
    end

    // User-side responder: supplies the next read byte on each tx_req.
    always @(negedge clk) begin
        if (tx_req) begin
            tx_req_cnt++;
            if (tx_q.size() != 0) tx_data = tx_q.pop_front();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        tick(2);
        m_low = ~b;
        tick(H - 2);
        scl = 1'b1;
        tick(H / 2);
        s = sda;
        tick(H / 2);
        scl = 1'b0;
    endtask

    task automatic do_start();
        tick(2);
        m_low = 1'b0;
        tick(H - 2);
        scl = 1'b1;
        tick(H);
        m_low = 1'b1;
        tick(H);
        scl = 1'b0;
    endtask

    task automatic do_stop();
        tick(2);
        m_low = 1'b1;
        tick(H - 2);
        scl = 1'b1;
        tick(H);
        m_low = 1'b0;
        tick(H);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic [7:0] t;
        logic       s;
        t = b;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(t[7], s);
            t = {t[6:0], 1'b0};
        end
        bit_xfer(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] b);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            b = {b[6:0], s};
        end
        bit_xfer(nack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;

        tick(3);
        expect_eq("reset_sda", 32'(sda), 32'd1);
        expect_eq("reset_rx_valid", 32'(rx_valid), 32'd0);
        expect_eq("reset_tx_req", 32'(tx_req), 32'd0);
        expect_eq("reset_busy", 32'(busy), 32'd0);
        expect_eq("reset_rd_mode", 32'(rd_mode), 32'd0);
        expect_eq("reset_rx_data", 32'(rx_data), 32'd0);
        reset_n = 1'b1;
        tick(4);

        // Write 0xA5, 0x3C to 0x50.
        exp_rx_q.push_back(8'hA5);
        exp_rx_q.push_back(8'h3C);
        do_start();
        wr_byte(8'hA0, ack);
        expect_eq("wr_addr_ack", 32'(ack), 32'd0);
        expect_eq("wr_busy_after_addr", 32'(busy), 32'd1);
        wr_byte(8'hA5, ack);
        expect_eq("wr_data1_ack", 32'(ack), 32'd0);
        wr_byte(8'h3C, ack);
        expect_eq("wr_data2_ack", 32'(ack), 32'd0);
        expect_eq("wr_busy_before_stop", 32'(busy), 32'd1);
        do_stop();
        tick(2);
        expect_eq("wr_busy_after_stop", 32'(busy), 32'd0);
        expect_eq("wr_sda_after_stop", 32'(sda), 32'd1);
        expect_eq("wr_rx_outstanding", 32'(exp_rx_q.size()), 32'd0);

        // Write to 0x51: not ours.
        do_start();
        wr_byte(8'hA2, ack);
        expect_eq("other_addr_ack", 32'(ack), 32'd1);
        expect_eq("other_busy", 32'(busy), 32'd0);
        wr_byte(8'h77, ack);
        expect_eq("other_data_ack", 32'(ack), 32'd1);
        expect_eq("other_busy_data", 32'(busy), 32'd0);
        do_stop();
        tick(2);

        // Repeated START after one write byte, then read one byte.
        exp_rx_q.push_back(8'hA5);
        tx_q.push_back(8'h81);
        do_start();
        wr_byte(8'hA0, ack);
        expect_eq("rs_wr_addr_ack", 32'(ack), 32'd0);
        wr_byte(8'hA5, ack);
        expect_eq("rs_wr_data_ack", 32'(ack), 32'd0);
        expect_eq("rs_rd_mode_wr", 32'(rd_mode), 32'd0);
        do_start();
        wr_byte(8'hA1, ack);
        expect_eq("rs_rd_addr_ack", 32'(ack), 32'd0);
        expect_eq("rs_rd_mode_rd", 32'(rd_mode), 32'd1);
        expect_eq("rs_busy", 32'(busy), 32'd1);
        rd_byte(1'b1, d);
        expect_eq("rs_rd_byte", 32'(d), 32'h81);
        expect_eq("rs_tx_req_cnt", 32'(tx_req_cnt), 32'd1);
        do_stop();
        tick(2);
        expect_eq("rs_sda_after_stop", 32'(sda), 32'd1);
        expect_eq("rs_busy_after_stop", 32'(busy), 32'd0);

        // Read 0xC3 (ACK) then 0x5A (NACK).
        tx_q.push_back(8'hC3);
        tx_q.push_back(8'h5A);
        do_start();
        wr_byte(8'hA1, ack);
        expect_eq("rd_addr_ack", 32'(ack), 32'd0);
        rd_byte(1'b0, d);
        expect_eq("rd_byte1", 32'(d), 32'hC3);
        rd_byte(1'b1, d);
        expect_eq("rd_byte2", 32'(d), 32'h5A);
        tick(6);
        expect_eq("rd_sda_after_nack", 32'(sda), 32'd1);
        expect_eq("rd_tx_req_cnt", 32'(tx_req_cnt), 32'd3);
        do_stop();
        tick(2);

        // STOP after four data bits.
        do_start();
        wr_byte(8'hA0, ack);
        expect_eq("stopmid_addr_ack", 32'(ack), 32'd0);
        bit_xfer(1'b1, s);
        bit_xfer(1'b0, s);
        bit_xfer(1'b1, s);
        bit_xfer(1'b1, s);
        do_stop();
        tick(2);
        expect_eq("stopmid_busy", 32'(busy), 32'd0);
        expect_eq("stopmid_sda", 32'(sda), 32'd1);

        // Reset while the target is driving a 0 data bit.
        tx_q.push_back(8'h3C);
        do_start();
        wr_byte(8'hA1, ack);
        expect_eq("rst_addr_ack", 32'(ack), 32'd0);
        bit_xfer(1'b1, s);
        expect_eq("rst_bit7", 32'(s), 32'd0);
        tick(6);
        expect_eq("rst_sda_driven", 32'(sda), 32'd0);
        reset_n = 1'b0;
        tick(1);
        expect_eq("rst_sda_released", 32'(sda), 32'd1);
        expect_eq("rst_busy", 32'(busy), 32'd0);
        expect_eq("rst_rd_mode", 32'(rd_mode), 32'd0);
        expect_eq("rst_rx_data", 32'(rx_data), 32'd0);
        expect_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        expect_eq("rst_tx_req", 32'(tx_req), 32'd0);
        expect_eq("rst_tx_req_cnt", 32'(tx_req_cnt), 32'd4);
        tick(2);
        reset_n = 1'b1;
        tick(4);

        // Normal write after reset.
        exp_rx_q.push_back(8'h96);
        do_start();
        wr_byte(8'hA0, ack);
        expect_eq("post_addr_ack", 32'(ack), 32'd0);
        wr_byte(8'h96, ack);
        expect_eq("post_data_ack", 32'(ack), 32'd0);
        do_stop();
        tick(4);
        expect_eq("post_rx_outstanding", 32'(exp_rx_q.size()), 32'd0);
        expect_eq("post_busy", 32'(busy), 32'd0);

        tick(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (responder) for the 7-bit-address, single-master bus driven by the team's I2C master. It oversamples SCL and SDA in the system clock domain and detects START, repeated START and STOP. It matches the address against a parameter and ACKs it, then delivers written bytes to the user side or serialises user-supplied bytes for reads. There is no clock stretching; SCL is input-only.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit bus address this target responds to
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- scl  input  1  bus clock from master
- sda  inout  1  open-drain data; driven 0 when sda_oe=1, else 1'bz
- rx_data  output  8  last byte written by master; valid when rx_valid=1
- rx_valid  output  1  one-clk pulse per received write byte
- tx_data  input  8  next byte to send on a read; sampled as defined under Timing
- tx_req  output  1  one-clk pulse requesting the next tx_data
- busy  output  1  1 while addressed (from address match to STOP/START)
- rd_mode  output  1  R/W bit of the current addressed transfer (1 = read)

## Operation
- Input conditioning: 2-flop synchronisers on scl and sda, both reset to 1, plus one registered copy of each for edge detection.
- Bus events, evaluated on synced signals:
  - scl_rise, scl_fall
  - START: sda falls while scl=1
  - STOP: sda rises while scl=1
- sda_oe registered; sda = sda_oe ? 1'b0 : 1'bz.
- States: IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- START from any state, including mid-byte (repeated start):
  - go to ADDR, clear bit counter and shift register, sda_oe=0, busy=0.
- STOP from any state: go to IDLE, sda_oe=0, busy=0.
- STOP/START take priority over the bit logic in the same clk.
- ADDR:
  - shift sda in MSB-first on each scl_rise; 3-bit counter.
  - After the 8th rise: if byte[7:1]==SLAVE_ADDR, set rd_mode=byte[0], busy=1, go ADDR_ACK.
  - Otherwise go IGNORE.
- ADDR_ACK:
  - Next scl_fall: sda_oe=1 (ACK).
  - Following scl_fall: go WR with sda_oe=0, or go RD.
  - If rd_mode=1, tx_req pulses on the first scl_fall of ADDR_ACK.
- WR:
  - Shift 8 bits on scl_rise.
  - On the 8th rise: rx_data<=byte, rx_valid=1 for one clk, go WR_ACK.
- WR_ACK: ACK every byte (sda_oe=1 on next scl_fall, release on the one after), then return to WR.
- RD:
  - On entry scl_fall: load shift register from tx_data; drive MSB (sda_oe=~bit).
  - Each subsequent scl_fall: shift and drive the next bit.
  - After the 8th bit, the next scl_fall releases sda (sda_oe=0) and goes RD_ACK.
- RD_ACK: sample sda on scl_rise.
  - 0 (ACK): pulse tx_req, go RD; the next scl_fall loads tx_data.
  - 1 (NACK): go IGNORE.
- IGNORE: sda_oe=0; wait for START or STOP.
- Reset values: state IDLE, sda_oe=0 (sda released), rx_data=0, rx_valid=0, tx_req=0, busy=0, rd_mode=0. Reset mid-transfer releases sda on the next clk edge.

## Timing
- Pin-to-event latency: 3 clk (2 sync + edge register). Outputs are registered one clk after the event.
- SCL high and low phases must each be ≥ 4 clk; no glitch filter beyond the synchroniser.
- sda_oe changes only on scl_fall (+1 clk), so SDA is stable while SCL is high, except for release on STOP/START.
- rx_valid asserts 1 clk after the 8th data scl_rise of each write byte.
- tx_req-to-sample window: at least one full SCL high phase. tx_data must be valid by the scl_fall ending the ACK slot.
- No byte buffering: rx_data is overwritten by the next byte about 9 SCL periods later.

## Test plan
- Write to 0x50, data 0xA5, 0x3C, STOP:
  - ACK driven low in the address slot and both data slots.
  - rx_valid pulses twice with rx_data=0xA5 then 0x3C.
  - busy high from the address ACK until STOP.
- Write to 0x51:
  - sda never driven; no rx_valid; busy stays 0; state IGNORE until STOP.
- Read from 0x50, tx_data 0xC3 then 0x5A; master ACKs byte 1 and NACKs byte 2:
  - sda bits 11000011 then 01011010 MSB-first.
  - tx_req pulses twice.
  - sda released after the NACK.
- Repeated START after the first write byte (0xA5), then read address 0x50:
  - rd_mode goes 0→1; new address ACKed; read proceeds.
- STOP injected mid-byte (after 4 data bits): state IDLE, sda released, no rx_valid.
- reset_n low mid-read while sda_oe=1:
  - sda released and all outputs at their reset values one clk later.
  - The next transfer works normally.
